// File: rtl/postbox_link_ctrl.sv
// postbox_link_ctrl
//   Single-clock link controller between the postcode test-port engine and
//   host-side byte streams.
//   RX path: bytes strobed in by the engine are buffered in a 16-entry FIFO
//   and handed to the host. pc_rxready throttles the engine while free space
//   is at or below the reserve.
//   TX path: host bytes are queued in a 16-entry FIFO. A small FSM offers one
//   byte at a time on pc_txdata/pc_tx_pending, retires it on a pc_txdone edge,
//   and then waits a fixed gap before arming the next byte.
//
// Ports
//   refclk, reset            clock, synchronous active-high reset
//   pc_rxdata, pc_rxstrobe   engine RX byte and async "byte ready" strobe
//   pc_rxready               engine may send more data
//   pc_txdata, pc_tx_pending byte offered to the engine, valid flag
//   pc_txdone                async "byte shifted out" strobe
//   rx_data/rx_valid/rx_ready  host RX stream
//   tx_data/tx_valid/tx_ready  host TX stream
//   rx_overflow, status_clr  sticky RX drop flag and its clear
//   tx_state_dbg             current TX FSM state
//
// Handshake: a transfer happens on a rising refclk edge where valid and ready
// are both high; valid never depends on ready within the same cycle.
module postbox_link_ctrl #(
  parameter int DEPTH_LOG2 = 4,
  parameter int RX_RESERVE = 2,
  parameter int TX_GAP     = 8
) (
  input  logic       refclk,
  input  logic       reset,
  input  logic [7:0] pc_rxdata,
  input  logic       pc_rxstrobe,
  output logic       pc_rxready,
  output logic [7:0] pc_txdata,
  output logic       pc_tx_pending,
  input  logic       pc_txdone,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  input  logic       rx_ready,
  input  logic [7:0] tx_data,
  input  logic       tx_valid,
  output logic       tx_ready,
  output logic       rx_overflow,
  input  logic       status_clr,
  output logic [1:0] tx_state_dbg
);

  localparam int DEPTH = 1 << DEPTH_LOG2;
  localparam int CW    = DEPTH_LOG2 + 1;
  localparam int GW    = (TX_GAP > 1) ? $clog2(TX_GAP) : 1;

  localparam logic [DEPTH_LOG2-1:0] PTR_ONE  = 1;
  localparam logic [CW-1:0]         CNT_ONE  = 1;
  localparam logic [CW-1:0]         CNT_FULL = CW'(DEPTH);
  localparam logic [CW-1:0]         RESERVE  = CW'(RX_RESERVE);
  localparam logic [GW-1:0]         GAP_ONE  = 1;
  localparam logic [GW-1:0]         GAP_LAST = GW'(TX_GAP - 1);

  typedef enum logic [1:0] {
    T_IDLE  = 2'd0,
    T_LOAD  = 2'd1,
    T_ARMED = 2'd2,
    T_GAP   = 2'd3
  } tx_state_t;

  // Strobe synchronisers. All flops reset to 1 so a strobe that is already
  // high when reset is released must be seen low before it can give an edge.
  // The edge is registered, which puts it 3 refclk after the async rise.
  logic rx_s1, rx_s2, rx_prev, rx_edge;
  logic tx_s1, tx_s2, tx_prev, tx_edge;

  always_ff @(posedge refclk) begin
    if (reset) begin
      rx_s1   <= 1'b1;
      rx_s2   <= 1'b1;
      rx_prev <= 1'b1;
      rx_edge <= 1'b0;
      tx_s1   <= 1'b1;
      tx_s2   <= 1'b1;
      tx_prev <= 1'b1;
      tx_edge <= 1'b0;
    end else begin
      rx_s1   <= pc_rxstrobe;
      rx_s2   <= rx_s1;
      rx_prev <= rx_s2;
      rx_edge <= rx_s2 & ~rx_prev;
      tx_s1   <= pc_txdone;
      tx_s2   <= tx_s1;
      tx_prev <= tx_s2;
      tx_edge <= tx_s2 & ~tx_prev;
    end
  end

  // RX push register: data is captured while the strobe is known to be high
  // and written into the FIFO on the following cycle.
  logic       rx_push;
  logic [7:0] rx_push_data;

  always_ff @(posedge refclk) begin
    if (reset) begin
      rx_push      <= 1'b0;
      rx_push_data <= 8'h00;
    end else begin
      rx_push <= rx_edge;
      if (rx_edge) rx_push_data <= pc_rxdata;
    end
  end

  // RX FIFO
  logic [7:0]            rx_mem [DEPTH];
  logic [DEPTH_LOG2-1:0] rx_wr_ptr, rx_rd_ptr;
  logic [CW-1:0]         rx_count;
  logic [CW-1:0]         rx_free;
  logic                  rx_full, rx_pop, rx_wr_en, rx_drop;

  assign rx_full  = (rx_count == CNT_FULL);
  assign rx_valid = (rx_count != '0);
  assign rx_pop   = rx_valid & rx_ready;
  // A pop in the same cycle makes room, so a push into a full FIFO succeeds.
  assign rx_wr_en = rx_push & (~rx_full | rx_pop);
  assign rx_drop  = rx_push & rx_full & ~rx_pop;
  assign rx_free  = CNT_FULL - rx_count;
  assign rx_data  = rx_valid ? rx_mem[rx_rd_ptr] : 8'h00;

  always_ff @(posedge refclk) begin
    if (rx_wr_en) rx_mem[rx_wr_ptr] <= rx_push_data;
  end

  always_ff @(posedge refclk) begin
    if (reset) begin
      rx_wr_ptr   <= '0;
      rx_rd_ptr   <= '0;
      rx_count    <= '0;
      rx_overflow <= 1'b0;
      pc_rxready  <= 1'b0;
    end else begin
      if (rx_wr_en) rx_wr_ptr <= rx_wr_ptr + PTR_ONE;
      if (rx_pop)   rx_rd_ptr <= rx_rd_ptr + PTR_ONE;
      case ({rx_wr_en, rx_pop})
        2'b10:   rx_count <= rx_count + CNT_ONE;
        2'b01:   rx_count <= rx_count - CNT_ONE;
        default: rx_count <= rx_count;
      endcase
      // A new drop outranks a simultaneous clear.
      if (rx_drop)         rx_overflow <= 1'b1;
      else if (status_clr) rx_overflow <= 1'b0;
      pc_rxready <= (rx_free > RESERVE);
    end
  end

  // TX FIFO
  logic [7:0]            tx_mem [DEPTH];
  logic [DEPTH_LOG2-1:0] tx_wr_ptr, tx_rd_ptr;
  logic [CW-1:0]         tx_count;
  logic                  tx_push, tx_pop;

  assign tx_ready = (tx_count != CNT_FULL);
  assign tx_push  = tx_valid & tx_ready;

  always_ff @(posedge refclk) begin
    if (tx_push) tx_mem[tx_wr_ptr] <= tx_data;
  end

  always_ff @(posedge refclk) begin
    if (reset) begin
      tx_wr_ptr <= '0;
      tx_rd_ptr <= '0;
      tx_count  <= '0;
    end else begin
      if (tx_push) tx_wr_ptr <= tx_wr_ptr + PTR_ONE;
      if (tx_pop)  tx_rd_ptr <= tx_rd_ptr + PTR_ONE;
      case ({tx_push, tx_pop})
        2'b10:   tx_count <= tx_count + CNT_ONE;
        2'b01:   tx_count <= tx_count - CNT_ONE;
        default: tx_count <= tx_count;
      endcase
    end
  end

  // TX FSM
  tx_state_t     tx_state, tx_state_nxt;
  logic [GW-1:0] gap_cnt, gap_nxt;

  assign tx_state_dbg = tx_state;

  always_ff @(posedge refclk) begin
    if (reset) begin
      tx_state  <= T_IDLE;
      gap_cnt   <= '0;
      pc_txdata <= 8'h00;
    end else begin
      tx_state <= tx_state_nxt;
      gap_cnt  <= gap_nxt;
      if (tx_pop) pc_txdata <= tx_mem[tx_rd_ptr];
    end
  end

  always_comb begin
    tx_state_nxt  = tx_state;
    gap_nxt       = gap_cnt;
    pc_tx_pending = 1'b0;
    tx_pop        = 1'b0;
    unique case (tx_state)
      T_IDLE: begin
        if (tx_count != '0) tx_state_nxt = T_LOAD;
      end
      T_LOAD: begin
        tx_pop       = 1'b1;
        tx_state_nxt = T_ARMED;
      end
      T_ARMED: begin
        pc_tx_pending = 1'b1;
        if (tx_edge) begin
          tx_state_nxt = T_GAP;
          gap_nxt      = '0;
        end
      end
      T_GAP: begin
        if (gap_cnt == GAP_LAST) tx_state_nxt = T_IDLE;
        else                     gap_nxt      = gap_cnt + GAP_ONE;
      end
      default: tx_state_nxt = T_IDLE;
    endcase
  end

endmodule

// File: tb/tb_postbox_link_ctrl.sv
`timescale 1ns/1ps
module tb_postbox_link_ctrl;

  localparam int TX_GAP = 8;
  localparam int DEPTH  = 16;
  localparam int RESV   = 2;

  // ---------------- clock / reset ----------------
  logic       refclk = 1'b0;
  logic       reset;
  logic [7:0] pc_rxdata;
  logic       pc_rxstrobe;
  logic       pc_rxready;
  logic [7:0] pc_txdata;
  logic       pc_tx_pending;
  logic       pc_txdone;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       rx_ready;
  logic [7:0] tx_data;
  logic       tx_valid;
  logic       tx_ready;
  logic       rx_overflow;
  logic       status_clr;
  logic [1:0] tx_state_dbg;

  always #5 refclk = ~refclk;

  postbox_link_ctrl #(.DEPTH_LOG2(4), .RX_RESERVE(RESV), .TX_GAP(TX_GAP)) dut (
    .refclk        (refclk),
    .reset         (reset),
    .pc_rxdata     (pc_rxdata),
    .pc_rxstrobe   (pc_rxstrobe),
    .pc_rxready    (pc_rxready),
    .pc_txdata     (pc_txdata),
    .pc_tx_pending (pc_tx_pending),
    .pc_txdone     (pc_txdone),
    .rx_data       (rx_data),
    .rx_valid      (rx_valid),
    .rx_ready      (rx_ready),
    .tx_data       (tx_data),
    .tx_valid      (tx_valid),
    .tx_ready      (tx_ready),
    .rx_overflow   (rx_overflow),
    .status_clr    (status_clr),
    .tx_state_dbg  (tx_state_dbg)
  );

  int vectors = 0;
  int fails   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  // Works from the observable rules: a strobe rise first seen at cycle c
  // lands in the RX FIFO at c+4 and retires a TX byte at c+3; host-side
  // queues hold the bytes; the TX side is a phase with a gap countdown.
  localparam int PH_IDLE = 0, PH_LOAD = 1, PH_ARMED = 2, PH_GAP = 3;

  logic [7:0] exp_q[$];
  logic [7:0] m_txq[$];
  int         rx_due[$];
  logic [7:0] rx_dat[$];
  int         tx_due[$];
  int         cyc = 0;
  bit         live = 0;
  bit         m_ov, m_rxready, m_rx_last, m_tx_last;
  logic [7:0] m_txdata;
  int         m_phase, m_gap_left;

  always @(posedge refclk) begin
    bit pop, drop, done;
    cyc++;
    live = 1;
    if (reset) begin
      exp_q.delete(); m_txq.delete(); rx_due.delete(); rx_dat.delete(); tx_due.delete();
      m_ov = 0; m_rxready = 0; m_rx_last = 1; m_tx_last = 1;
      m_txdata = 8'h00; m_phase = PH_IDLE; m_gap_left = 0;
    end else begin
      m_rxready = (DEPTH - exp_q.size()) > RESV;
      if (pc_rxstrobe && !m_rx_last) begin
        rx_due.push_back(cyc + 4);
        rx_dat.push_back(pc_rxdata);
      end
      m_rx_last = pc_rxstrobe;
      if (pc_txdone && !m_tx_last) tx_due.push_back(cyc + 3);
      m_tx_last = pc_txdone;

      // RX FIFO
      pop  = (exp_q.size() > 0) && rx_ready;
      drop = 0;
      if (pop) void'(exp_q.pop_front());
      if (rx_due.size() > 0 && rx_due[0] == cyc) begin
        logic [7:0] d;
        void'(rx_due.pop_front());
        d = rx_dat.pop_front();
        if (exp_q.size() < DEPTH) exp_q.push_back(d);
        else drop = 1;
      end
      if (status_clr) m_ov = 0;
      if (drop) m_ov = 1;

      // TX side
      done = 0;
      if (tx_due.size() > 0 && tx_due[0] == cyc) begin
        void'(tx_due.pop_front());
        done = 1;
      end
      case (m_phase)
        PH_IDLE:  if (m_txq.size() > 0) m_phase = PH_LOAD;
        PH_LOAD:  begin m_txdata = m_txq.pop_front(); m_phase = PH_ARMED; end
        PH_ARMED: if (done) begin m_phase = PH_GAP; m_gap_left = TX_GAP; end
        default: begin
          m_gap_left--;
          if (m_gap_left == 0) m_phase = PH_IDLE;
        end
      endcase
      if (tx_valid && m_txq.size() < DEPTH) m_txq.push_back(tx_data);
    end
  end

  // ---------------- per-cycle compare ----------------
  logic [7:0] got_q[$];

  always @(negedge refclk) begin
    if (live) begin
      check("rx_valid",      32'(rx_valid),      32'(exp_q.size() != 0));
      check("rx_data",       32'(rx_data),       32'((exp_q.size() != 0) ? exp_q[0] : 8'h00));
      check("rx_overflow",   32'(rx_overflow),   32'(m_ov));
      check("pc_rxready",    32'(pc_rxready),    32'(m_rxready));
      check("tx_ready",      32'(tx_ready),      32'(m_txq.size() < DEPTH));
      check("pc_tx_pending", 32'(pc_tx_pending), 32'(m_phase == PH_ARMED));
      check("pc_txdata",     32'(pc_txdata),     32'(m_txdata));
      if (rx_valid && rx_ready) got_q.push_back(rx_data);
    end
  end

  // ---------------- driver tasks ----------------
  task automatic tick(input int n = 1);
    repeat (n) begin
      @(posedge refclk);
      #2;
    end
  endtask

  task automatic rx_byte(input logic [7:0] d);
    pc_rxdata   = d;
    pc_rxstrobe = 1'b1;
    tick(4);
    pc_rxstrobe = 1'b0;
    tick(4);
  endtask

  task automatic tx_push(input logic [7:0] d);
    tx_data  = d;
    tx_valid = 1'b1;
    tick();
    tx_valid = 1'b0;
  endtask

  task automatic txdone_pulse();
    pc_txdone = 1'b1;
    tick(3);
    pc_txdone = 1'b0;
    tick(3);
  endtask

  task automatic wait_pending(input string name);
    int t;
    for (t = 0; t < 40; t++) begin
      if (pc_tx_pending) break;
      tick();
    end
    if (!pc_tx_pending) begin
      vectors++;
      fails++;
      $display("FAIL %s: pc_tx_pending timeout, got 0 expected 1", name);
    end
  endtask

  // ---------------- directed tests ----------------
  initial begin
    int low_cnt;
    bit seen_low;
    reset = 1'b1; pc_rxdata = 8'h00; pc_rxstrobe = 1'b0; pc_txdone = 1'b0;
    rx_ready = 1'b0; tx_data = 8'h00; tx_valid = 1'b0; status_clr = 1'b0;
    tick(2);
    check("reset_rxready", 32'(pc_rxready), 32'h0);
    check("reset_tx_ready", 32'(tx_ready), 32'h1);
    check("reset_txdata", 32'(pc_txdata), 32'h00);
    reset = 1'b0;
    tick(2);

    // 1: RX burst
    rx_ready = 1'b1;
    got_q.delete();
    rx_byte(8'hA5); rx_byte(8'h3C); rx_byte(8'hFF);
    tick(6);
    check("burst_count", 32'(got_q.size()), 32'd3);
    if (got_q.size() == 3) begin
      check("burst_b0", 32'(got_q[0]), 32'hA5);
      check("burst_b1", 32'(got_q[1]), 32'h3C);
      check("burst_b2", 32'(got_q[2]), 32'hFF);
    end
    check("burst_ovf", 32'(rx_overflow), 32'h0);

    // 2: throttle and overflow
    rx_ready = 1'b0;
    for (int i = 0; i < 13; i++) rx_byte(8'h40 + 8'(i));
    check("thr_ready13", 32'(pc_rxready), 32'h1);
    rx_byte(8'h4D);
    check("thr_ready14", 32'(pc_rxready), 32'h0);
    rx_byte(8'h4E); rx_byte(8'h4F);
    check("thr_ovf16", 32'(rx_overflow), 32'h0);
    rx_byte(8'h99);
    check("thr_ovf17", 32'(rx_overflow), 32'h1);
    status_clr = 1'b1;
    tick();
    status_clr = 1'b0;
    check("thr_clr", 32'(rx_overflow), 32'h0);
    got_q.delete();
    rx_ready = 1'b1;
    tick(20);
    check("drain_count", 32'(got_q.size()), 32'd16);
    for (int i = 0; i < 16; i++)
      if (i < got_q.size()) check("drain_byte", 32'(got_q[i]), 32'h40 + 32'(i));
    check("drain_ready", 32'(pc_rxready), 32'h1);

    // 3: TX with gap
    tx_push(8'h12); tx_push(8'h34);
    wait_pending("tx_first");
    check("tx_first_data", 32'(pc_txdata), 32'h12);
    pc_txdone = 1'b1;
    low_cnt = 0; seen_low = 0;
    for (int t = 0; t < 60; t++) begin
      tick();
      if (t == 3) pc_txdone = 1'b0;
      if (!pc_tx_pending) begin
        seen_low = 1;
        low_cnt++;
      end else if (seen_low) break;
    end
    pc_txdone = 1'b0;
    check("tx_gap_low", 32'(low_cnt), 32'(TX_GAP + 2));
    check("tx_second_pend", 32'(pc_tx_pending), 32'h1);
    check("tx_second_data", 32'(pc_txdata), 32'h34);

    // 4: spurious txdone during T_GAP and T_IDLE
    tx_push(8'h56);
    pc_txdone = 1'b1; tick(3);
    pc_txdone = 1'b0; tick(2);
    pc_txdone = 1'b1; tick(2);
    pc_txdone = 1'b0;
    wait_pending("gap_spur");
    check("gap_spur_data", 32'(pc_txdata), 32'h56);
    tick(4);
    check("gap_spur_hold", 32'(pc_tx_pending), 32'h1);
    txdone_pulse();
    tick(16);
    txdone_pulse();
    tick(4);
    check("idle_spur_pend", 32'(pc_tx_pending), 32'h0);
    check("idle_spur_data", 32'(pc_txdata), 32'h56);
    tx_push(8'h78);
    wait_pending("idle_after");
    check("idle_after_data", 32'(pc_txdata), 32'h78);

    // 6: reset while armed
    tx_push(8'h9A); tx_push(8'hBC);
    rx_ready = 1'b0;
    rx_byte(8'h11);
    check("pre_rst_rxv", 32'(rx_valid), 32'h1);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check("rst_pend", 32'(pc_tx_pending), 32'h0);
    check("rst_tx_ready", 32'(tx_ready), 32'h1);
    check("rst_rx_valid", 32'(rx_valid), 32'h0);
    check("rst_txdata", 32'(pc_txdata), 32'h00);
    tick(6);
    check("rst_stay_idle", 32'(pc_tx_pending), 32'h0);

    // 5: strobe held high across reset release
    pc_rxdata = 8'hE7;
    pc_rxstrobe = 1'b1;
    reset = 1'b1;
    tick(2);
    reset = 1'b0;
    tick(8);
    check("held_no_push", 32'(rx_valid), 32'h0);
    pc_rxstrobe = 1'b0;
    tick(3);
    rx_byte(8'hC3);
    check("held_then_push", 32'(rx_valid), 32'h1);
    check("held_then_data", 32'(rx_data), 32'hC3);
    tick(2);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, fails);
    $finish;
  end

endmodule
